multi_echo: RTL
===============

MULTI_ECHO -- requirements
Module: multi_echo

Interface
REQ-001 Parameter W, default 16: signed sample width in bits.
REQ-002 Parameter CHANNELS, default 4: number of independent echo channels.
REQ-003 Parameter ADDR_W, default 11: per-channel delay-line depth is DEPTH = 2^ADDR_W samples.
REQ-004 Parameter DECIMATE, default 2: one of every 2^DECIMATE sample strobes is processed.
REQ-005 clk  in  1  sole clock; every register updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 sample_strobe  in  1  one-clk pulse marking a new input frame.
REQ-008 sample_in  in  CHANNELS*W  signed samples; channel c occupies bits [c*W +: W].
REQ-009 delay_len  in  ADDR_W  tap distance in processed samples, shared by all channels.
REQ-010 feedback  in  8  unsigned feedback gain in Q0.8, so 255 = 255/256.
REQ-011 sample_out  out  CHANNELS*W  signed echo (wet-only) outputs, packed as sample_in.
REQ-012 out_valid  out  1  one-clk pulse when sample_out has been updated.
REQ-013 busy  out  1  high during the clear sweep or while a frame is being processed.
REQ-014 overrun  out  1  sticky flag, set when a strobe is ignored because busy is high.

Function
REQ-015 Storage SHALL be one RAM of CHANNELS*DEPTH words of W bits, addressed {channel, pointer}, with a registered (1-clk) read.
REQ-016 States SHALL be CLEAR, IDLE, READ, CALC, WRITE, DONE.
REQ-017 CLEAR writes 0 to one address per clk, from 0 to CHANNELS*DEPTH-1, then enters IDLE; busy is high throughout.
REQ-018 IDLE, on sample_strobe:
  - decimation counter dcnt==0 -> latch sample_in, delay_len and feedback; set ch=0; go to READ.
  - any other dcnt -> the strobe is consumed with no processing.
  - dcnt increments modulo 2^DECIMATE on every strobe accepted in IDLE.
REQ-019 READ: issue read at {ch, wptr - delay_len} (modulo DEPTH); next state CALC.
REQ-020 CALC:
  - capture tap.
  - prod = tap * {0,feedback}, signed, W+9 bits.
  - fb = prod >>> 8 (arithmetic, floor).
  - sum = in[ch] + fb in W+1 bits, saturated to [-2^(W-1), 2^(W-1)-1].
  - next state WRITE.
REQ-021 WRITE: write sum at {ch, wptr}; hold tap into a staging register for channel ch; if ch==CHANNELS-1 go to DONE, else increment ch and go to READ.
REQ-022 DONE: copy all staging registers to sample_out simultaneously; pulse out_valid; increment wptr modulo DEPTH; return to IDLE.
REQ-023 Latency SHALL be 3*CHANNELS+1 clk from the accepting strobe to out_valid; sample_out holds its value between updates.
REQ-024 delay_len==0 SHALL read the location about to be overwritten, giving a delay of DEPTH processed samples.
REQ-025 delay_len==1 reads the previous frame's write; read-before-write order holds within a channel.
REQ-026 A strobe arriving while busy is high SHALL be ignored (no dcnt change) and SHALL set overrun; overrun clears only on reset.
REQ-027 Changes to delay_len and feedback mid-frame SHALL NOT affect the frame already in progress.
REQ-028 Each channel's data path SHALL be independent: no cross-channel mixing.

Reset
REQ-029 Asserting rst_n low at any time, including mid-frame or mid-CLEAR, SHALL immediately force:
  - sample_out=0, out_valid=0, overrun=0;
  - wptr=0, dcnt=0, ch=0, staging registers=0;
  - state=CLEAR with busy=1.
REQ-030 After rst_n rises, the CLEAR sweep restarts from address 0 and lasts exactly CHANNELS*DEPTH clk; RAM contents are not otherwise reset.

Verification (CHANNELS=2, ADDR_W=4, W=16, DECIMATE=0 unless stated)
REQ-031 Release reset -> busy high for exactly 32 clk; sample_out=0; strobes during the sweep set overrun.
REQ-032 delay_len=3, feedback=0, ch0 input 1000 on frame k and 0 otherwise -> sample_out0=1000 only at out_valid of frame k+3; ch1 stays 0.
REQ-033 delay_len=2, feedback=128, impulse 1000 on frame k -> sample_out0 = 1000, 500, 250, 125 at frames k+2, k+4, k+6, k+8.
REQ-034 Constant input 30000, feedback=255, delay_len=1 -> writes clamp at 32767; sample_out0 never goes negative. Mirror test with -30000 clamps at -32768.
REQ-035 delay_len=0, impulse 1000 -> output 1000 at frame k+16. DECIMATE=2 -> exactly one out_valid per 4 strobes, the first on the first strobe.
REQ-036 Strobe issued 2 clk after an accepted strobe -> overrun=1 and the next out_valid arrives 7 clk after the first strobe. rst_n pulsed low mid-frame -> outputs 0 and busy for 32 clk.

Source files
------------

// File: rtl/multi_echo.sv
`default_nettype none
// ============================================================================
// multi_echo : multi-channel feedback echo over one shared delay-line RAM
// Revision   : 1.0
// ============================================================================
module multi_echo #(
    parameter int W        = 16,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 11,
    parameter int DECIMATE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_strobe,
    input  logic [CHANNELS*W-1:0] sample_in,
    input  logic [ADDR_W-1:0]     delay_len,
    input  logic [7:0]            feedback,
    output logic [CHANNELS*W-1:0] sample_out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int A_W   = CH_W + ADDR_W;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int WORDS = CHANNELS * DEPTH;
    localparam int DC_W  = (DECIMATE > 0) ? DECIMATE : 1;

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_READ, S_CALC, S_WRITE, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [A_W-1:0]        clr_q, clr_d;
    logic [ADDR_W-1:0]     wptr_q, wptr_d;
    logic [DC_W-1:0]       dcnt_q, dcnt_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [CHANNELS*W-1:0] in_q, in_d;
    logic [ADDR_W-1:0]     dl_q, dl_d;
    logic [7:0]            fb_q, fb_d;
    logic [W-1:0]          tap_q, tap_d;
    logic [W-1:0]          sum_q, sum_d;
    logic [CHANNELS*W-1:0] stage_q, stage_d;
    logic [CHANNELS*W-1:0] out_q, out_d;
    logic                  valid_q, valid_d;
    logic                  ovr_q, ovr_d;

    logic [W-1:0]          mem [WORDS];
    logic [W-1:0]          rd_q;
    logic                  w_we;
    logic [A_W-1:0]        w_waddr;
    logic [A_W-1:0]        w_raddr;
    logic [W-1:0]          w_wdata;

    logic signed [W-1:0]   w_in_ch;
    logic signed [8:0]     w_gain;
    logic signed [W+8:0]   w_prod;
    logic signed [W:0]     w_fb;
    logic signed [W:0]     w_sum;
    logic [W-1:0]          w_sat;
    logic                  w_unused_lsb;

    // Single-port-style RAM: one write and one registered read per clk.
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[w_waddr] <= w_wdata;
        end
        if (state_q == S_READ) begin
            rd_q <= mem[w_raddr];
        end
    end

    assign w_we    = (state_q == S_CLEAR) || (state_q == S_WRITE);
    assign w_waddr = (state_q == S_CLEAR) ? clr_q : {ch_q, wptr_q};
    assign w_wdata = (state_q == S_CLEAR) ? '0 : sum_q;
    assign w_raddr = {ch_q, wptr_q - dl_q};

    // Feedback path: floor(tap * gain / 256) + input, saturated to W bits.
    assign w_in_ch      = $signed(in_q[ch_q*W +: W]);
    assign w_gain       = $signed({1'b0, fb_q});
    assign w_prod       = $signed(rd_q) * w_gain;
    assign w_fb         = w_prod[W+8:8];
    assign w_unused_lsb = ^w_prod[7:0];
    assign w_sum        = $signed({w_in_ch[W-1], w_in_ch}) + w_fb;

    always_comb begin
        w_sat = w_sum[W-1:0];
        if (w_sum[W] != w_sum[W-1]) begin
            w_sat = w_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        wptr_d  = wptr_q;
        dcnt_d  = dcnt_q;
        ch_d    = ch_q;
        in_d    = in_q;
        dl_d    = dl_q;
        fb_d    = fb_q;
        tap_d   = tap_q;
        sum_d   = sum_q;
        stage_d = stage_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q;

        if (sample_strobe && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            S_CLEAR: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == A_W'(WORDS - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (sample_strobe) begin
                    if (DECIMATE > 0) begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                    if (dcnt_q == '0) begin
                        in_d    = sample_in;
                        dl_d    = delay_len;
                        fb_d    = feedback;
                        ch_d    = '0;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                state_d = S_CALC;
            end
            S_CALC: begin
                tap_d   = rd_q;
                sum_d   = w_sat;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                stage_d[ch_q*W +: W] = tap_q;
                if (ch_q == CH_W'(CHANNELS - 1)) begin
                    // Outputs land together with the out_valid pulse in DONE.
                    out_d   = stage_d;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                wptr_d  = wptr_q + 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            clr_q   <= '0;
            wptr_q  <= '0;
            dcnt_q  <= '0;
            ch_q    <= '0;
            in_q    <= '0;
            dl_q    <= '0;
            fb_q    <= '0;
            tap_q   <= '0;
            sum_q   <= '0;
            stage_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            wptr_q  <= wptr_d;
            dcnt_q  <= dcnt_d;
            ch_q    <= ch_d;
            in_q    <= in_d;
            dl_q    <= dl_d;
            fb_q    <= fb_d;
            tap_q   <= tap_d;
            sum_q   <= sum_d;
            stage_q <= stage_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign sample_out = out_q;
    assign out_valid  = valid_q;
    assign busy       = (state_q != S_IDLE);
    assign overrun    = ovr_q;

endmodule
`default_nettype wire
